// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: start/done request bus between a requester and the nibble-serial adder sequencer
interface adder_seq_ctrl_if #(parameter int NIBBLES = 4);
    localparam int WIDTH = 4 * NIBBLES;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    modport master (output start, a, b, cin, input busy, done, result, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, result, cout, ovf);
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: adds two WIDTH-bit operands one nibble per cycle through a shared 4-bit adder
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module adder_seq_ctrl #(parameter int NIBBLES = 4) (
    input  logic             clk,
    input  logic             rst,
    adder_seq_ctrl_if.slave  bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IW    = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [IW-1:0]    r_idx;
    logic             r_carry, r_cout, r_ovf;
    logic [3:0]       w_sum;
    logic             w_cout, w_last, w_accept;
    adder_4bit u_add (
        .a    (r_a[4*r_idx +: 4]),
        .b    (r_b[4*r_idx +: 4]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );
    assign w_last   = r_idx == IW'(NIBBLES - 1);
    assign w_accept = r_state == IDLE && bus.start;
    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (bus.start ? RUN : IDLE) :
                 r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_carry  <= bus.cin;
                r_idx    <= '0;
                r_result <= '0;
                r_cout   <= 1'b0;
                r_ovf    <= 1'b0;
            end else if (r_state == RUN) begin
                r_result[4*r_idx +: 4] <= w_sum;
                r_carry                <= w_cout;
                r_idx                  <= r_idx + IW'(1);
                if (w_last) begin
                    r_cout <= w_cout;
                    r_ovf  <= r_a[WIDTH-1] == r_b[WIDTH-1] && w_sum[3] != r_a[WIDTH-1];
                end
            end
        end
    end
    assign bus.busy   = r_state != IDLE;
    assign bus.done   = r_state == DONE;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed vectors checked against literals and a per-cycle transaction model
module tb_adder_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    adder_seq_ctrl_if #(.NIBBLES(N)) bus ();
    adder_seq_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: k counts edges since accept, -1 when idle; sum computed from latched operands
    int         k = -1;
    logic [W-1:0] m_a, m_b, m_res;
    logic       m_cin, m_cout, m_ovf;
    logic [W:0] m_sum;
    assign m_sum = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);
    always @(posedge clk) begin
        if (rst) begin
            k      <= -1;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (k < 0) begin
            if (bus.start) begin
                k      <= 0;
                m_a    <= bus.a;
                m_b    <= bus.b;
                m_cin  <= bus.cin;
                m_res  <= '0;
                m_cout <= 1'b0;
                m_ovf  <= 1'b0;
            end
        end else begin
            k <= k == N ? -1 : k + 1;
            if (k == N - 1) begin
                m_res  <= m_sum[W-1:0];
                m_cout <= m_sum[W];
                m_ovf  <= m_a[W-1] == m_b[W-1] && m_sum[W-1] != m_a[W-1];
            end
        end
    end
    always @(negedge clk) begin
        chk("model_busy", 64'(bus.busy), 64'(k >= 0));
        chk("model_done", 64'(bus.done), 64'(k == N));
        chk("model_cout", 64'(bus.cout), 64'(m_cout));
        chk("model_ovf", 64'(bus.ovf), 64'(m_ovf));
        if (k < 0 || k == N) chk("model_result", 64'(bus.result), 64'(m_res));
    end
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] er, input logic ec, input logic eo, input string nm);
        int n;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = W'($urandom);
        bus.cin   = ~c;
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(N + 1));
        chk({nm, "_result"}, 64'(bus.result), 64'(er));
        chk({nm, "_cout"}, 64'(bus.cout), 64'(ec));
        chk({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
        chk({nm, "_model"}, 64'({m_cout, m_res}), 64'({ec, er}));
        @(negedge clk);
        chk({nm, "_hold"}, 64'(bus.result), 64'(er));
    endtask
    initial begin
        int cnt;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] rs;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "carry_chain");
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        op(16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, "wrap_cin");
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
        op(16'hA5C3, 16'h0F0F, 1'b1, 16'hB4D3, 1'b0, 1'b0, "mixed");
        // start while busy is ignored; a new start lands only after the idle cycle
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_done", 64'(bus.done), 64'd1);
        chk("busy_result", 64'(bus.result), 64'h5556);
        chk("busy_t5", 64'(bus.busy), 64'd1);
        bus.start = 1'b1; bus.a = 16'h0002; bus.b = 16'h0003; bus.cin = 1'b0;
        @(negedge clk);
        chk("busy_t6_idle", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("busy_t7_run", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("busy_next_result", 64'(bus.result), 64'h0005);
        @(negedge clk);
        // reset mid-operation discards it
        bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_result", 64'(bus.result), 64'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(bus.done);
        end
        chk("midrst_no_done", 64'(cnt), 64'd0);
        op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, "after_rst");
        // start held high re-triggers every issue interval
        bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0;
        cnt = 0;
        repeat (3 * (N + 2)) begin
            @(negedge clk);
            cnt += int'(bus.done);
        end
        bus.start = 1'b0;
        chk("held_start_dones", 64'(cnt), 64'd3);
        chk("held_start_idle", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            op(ra, rb, rc, rs[W-1:0], rs[W], ra[W-1] == rb[W-1] && rs[W-1] != ra[W-1], "random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
